fft_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_delay_line.sv | 35 +++
 rtl/fft_sequencer.sv | 108 ++++++++++
 tb/tb_fft_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Constants and FSM encoding shared by the FFT sequencer, the AGU and their benches.
package fft_pkg;

  localparam int N       = 32;
  localparam int LOG2N   = $clog2(N);
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int PAIR_W  = $clog2(N / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Synchronous-reset shift register that aligns a bus by DEPTH cycles; DEPTH=0 is a wire.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset are intentionally unused when there is nothing to store.
      logic unused_ok;
      assign unused_ok = ^{clk, reset};
      assign dout      = din;
    end else begin : g_shift
      logic [WIDTH-1:0] pipe [DEPTH];

      // NOTE: the storage is reset on purpose, so a stale strobe never emerges after a reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_sequencer.sv
// Radix-2 FFT stage/pair sequencer: issues reads, aligns write-back strobes, drains between stages.
module fft_sequencer #(
  parameter  int N            = fft_pkg::N,
  parameter  int BFLY_LATENCY = 4,
  localparam int LOG2N        = $clog2(N),
  localparam int STAGE_W      = $clog2(LOG2N),
  localparam int PAIR_W       = $clog2(N / 2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [STAGE_W-1:0] stage,
  output logic [PAIR_W-1:0]  pair_id,
  output logic               rd_en,
  output logic               wr_en,
  output logic [STAGE_W-1:0] wr_stage,
  output logic [PAIR_W-1:0]  wr_pair_id,
  output logic               busy,
  output logic               done
);

  localparam int DLY_W = 1 + STAGE_W + PAIR_W;
  localparam logic [PAIR_W-1:0]  PAIR_LAST  = PAIR_W'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [3:0]         DRAIN_LAST = (BFLY_LATENCY > 0) ? 4'(BFLY_LATENCY - 1) : 4'd0;

  fft_pkg::state_t  state;
  logic [3:0]       drain_cnt;
  logic [DLY_W-1:0] wr_bus;

  // NOTE: all state and outputs here are flops, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= fft_pkg::IDLE;
      stage     <= '0;
      pair_id   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        fft_pkg::IDLE: begin
          if (start) begin
            state   <= fft_pkg::RUN;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            stage   <= '0;
            pair_id <= '0;
          end
        end
        fft_pkg::RUN: begin
          if (pair_id != PAIR_LAST) begin
            pair_id <= pair_id + 1'b1;
          end else if (BFLY_LATENCY > 0) begin
            state     <= fft_pkg::DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else if (stage != STAGE_LAST) begin
            stage   <= stage + 1'b1;
            pair_id <= '0;
          end else begin
            state   <= fft_pkg::DONE;
            rd_en   <= 1'b0;
            done    <= 1'b1;
            stage   <= '0;
            pair_id <= '0;
          end
        end
        fft_pkg::DRAIN: begin
          // Stage and pair hold here so the AGU sees a stable address during the gap.
          if (drain_cnt != DRAIN_LAST) begin
            drain_cnt <= drain_cnt + 1'b1;
          end else if (stage != STAGE_LAST) begin
            state   <= fft_pkg::RUN;
            rd_en   <= 1'b1;
            stage   <= stage + 1'b1;
            pair_id <= '0;
          end else begin
            state   <= fft_pkg::DONE;
            done    <= 1'b1;
            stage   <= '0;
            pair_id <= '0;
          end
        end
        fft_pkg::DONE: begin
          state <= fft_pkg::IDLE;
          busy  <= 1'b0;
        end
        default: state <= fft_pkg::IDLE;
      endcase
    end
  end

  fft_delay_line #(
    .WIDTH (DLY_W),
    .DEPTH (BFLY_LATENCY)
  ) u_wr_align (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_en, stage, pair_id}),
    .dout  (wr_bus)
  );

  assign {wr_en, wr_stage, wr_pair_id} = wr_bus;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: two instances (latency 4 and 0) checked cycle by cycle against a schedule model.
module tb_fft_sequencer;
  import fft_pkg::*;

  localparam int LAT = 4;
  localparam int H   = N / 2;

  typedef struct packed {
    logic               rd_en;
    logic [STAGE_W-1:0] stage;
    logic [PAIR_W-1:0]  pair_id;
    logic               wr_en;
    logic [STAGE_W-1:0] wr_stage;
    logic [PAIR_W-1:0]  wr_pair_id;
    logic               busy;
    logic               done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_a, start_a, reset_z, start_z;
  logic [STAGE_W-1:0] stage_a, wr_stage_a, stage_z, wr_stage_z;
  logic [PAIR_W-1:0]  pair_id_a, wr_pair_id_a, pair_id_z, wr_pair_id_z;
  logic               rd_en_a, wr_en_a, busy_a, done_a;
  logic               rd_en_z, wr_en_z, busy_z, done_z;

  int n_tests = 0;
  int n_fail  = 0;

  fft_sequencer #(.BFLY_LATENCY(LAT)) dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .start      (start_a),
    .stage      (stage_a),
    .pair_id    (pair_id_a),
    .rd_en      (rd_en_a),
    .wr_en      (wr_en_a),
    .wr_stage   (wr_stage_a),
    .wr_pair_id (wr_pair_id_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  fft_sequencer #(.BFLY_LATENCY(0)) dut_z (
    .clk        (clk),
    .reset      (reset_z),
    .start      (start_z),
    .stage      (stage_z),
    .pair_id    (pair_id_z),
    .rd_en      (rd_en_z),
    .wr_en      (wr_en_z),
    .wr_stage   (wr_stage_z),
    .wr_pair_id (wr_pair_id_z),
    .busy       (busy_z),
    .done       (done_z)
  );

  // Read-side schedule of one run, t = cycles since the first issue: each stage is H issues
  // followed by lat idle cycles; the done cycle comes right after the last stage's gap.
  function automatic obs_t rd_side(int lat, int t);
    int per  = H + lat;
    int last = LOG2N * per;
    int s, r;
    obs_t o = '0;
    if (t >= 0 && t < last) begin
      s         = t / per;
      r         = t % per;
      o.busy    = 1'b1;
      o.stage   = STAGE_W'(s);
      o.rd_en   = (r < H);
      o.pair_id = PAIR_W'((r < H) ? r : H - 1);
    end else if (t == last) begin
      o.busy = 1'b1;
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Optionally a second run launched one idle cycle after the first one's done.
  function automatic obs_t run_rd(int lat, int t, bit again);
    obs_t o = rd_side(lat, t);
    if (again) o = o | rd_side(lat, t - (LOG2N * (H + lat) + 2));
    return o;
  endfunction

  function automatic obs_t expect_at(int lat, int t, bit again);
    obs_t o = run_rd(lat, t, again);
    obs_t w = run_rd(lat, t - lat, again);
    o.wr_en      = w.rd_en;
    o.wr_stage   = w.stage;
    o.wr_pair_id = w.pair_id;
    return o;
  endfunction

  function automatic obs_t observe(bit z);
    obs_t o;
    if (z) begin
      o.rd_en = rd_en_z; o.stage = stage_z; o.pair_id = pair_id_z;
      o.wr_en = wr_en_z; o.wr_stage = wr_stage_z; o.wr_pair_id = wr_pair_id_z;
      o.busy  = busy_z;  o.done = done_z;
    end else begin
      o.rd_en = rd_en_a; o.stage = stage_a; o.pair_id = pair_id_a;
      o.wr_en = wr_en_a; o.wr_stage = wr_stage_a; o.wr_pair_id = wr_pair_id_a;
      o.busy  = busy_a;  o.done = done_a;
    end
    return o;
  endfunction

  task automatic set_start(input bit z, input logic v);
    if (z) start_z = v;
    else   start_a = v;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Launches a run and compares every cycle up to stop_t against the model.
  task automatic play_run(input bit z, input int lat, input int stop_t, input bit inject,
                          input bit again, output int wr_cnt, output int rd_cnt,
                          output int done_cnt, output int done_t, output int hazard_bad);
    int   first_rd [LOG2N];
    int   last_wr  [LOG2N];
    int   last = LOG2N * (H + lat);
    obs_t got, exp;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_t = -1; hazard_bad = 0;
    for (int k = 0; k < LOG2N; k++) begin
      first_rd[k] = -1;
      last_wr[k]  = -1;
    end
    set_start(z, 1'b1);
    for (int t = 0; t <= stop_t; t++) begin
      @(posedge clk);
      #1;
      set_start(z, 1'b0);
      if (inject && t > 0 && t <= last && (t == H + 1 || t == last || $urandom_range(0, 3) == 0))
        set_start(z, 1'b1);
      if (again && t == last + 1) set_start(z, 1'b1);
      got = observe(z);
      exp = expect_at(lat, t, again);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL trace lat=%0d t=%0d got=%h expected=%h", lat, t, got, exp);
      end
      if (got.wr_en) wr_cnt++;
      if (got.rd_en) rd_cnt++;
      if (got.done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (t < last) begin
        if (got.rd_en && int'(got.stage) < LOG2N && first_rd[got.stage] < 0) first_rd[got.stage] = t;
        if (got.wr_en && int'(got.wr_stage) < LOG2N) last_wr[got.wr_stage] = t;
      end
    end
    for (int k = 1; k < LOG2N; k++)
      if (first_rd[k] < 0 || first_rd[k] != last_wr[k-1] + 1) hazard_bad++;
  endtask

  task automatic test_reset();
    obs_t got;
    reset_a = 1'b1; reset_z = 1'b1; start_a = 1'b0; start_z = 1'b0;
    idle_cycles(2);
    for (int z = 0; z < 2; z++) begin
      got = observe(z[0]);
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d got=%h expected=0", z, got);
      end
    end
    reset_a = 1'b0; reset_z = 1'b0;
  endtask

  task automatic test_idle();
    obs_t got;
    for (int c = 0; c < 50; c++) begin
      idle_cycles(1);
      for (int z = 0; z < 2; z++) begin
        got = observe(z[0]);
        n_tests++;
        if (got !== '0) begin
          n_fail++;
          $display("FAIL idle dut=%0d cycle=%0d got=%h expected=0", z, c, got);
        end
      end
    end
  endtask

  task automatic test_basic_run();
    int wr, rd, dn, dt, hz;
    int last = LOG2N * (H + LAT);
    idle_cycles($urandom_range(LAT + 1, 12));
    play_run(1'b0, LAT, last + LAT + 3, 1'b0, 1'b0, wr, rd, dn, dt, hz);
    n_tests += 5;
    if (wr !== LOG2N * H) begin n_fail++; $display("FAIL basic_wr_count got=%0d expected=%0d", wr, LOG2N * H); end
    if (rd !== LOG2N * H) begin n_fail++; $display("FAIL basic_rd_count got=%0d expected=%0d", rd, LOG2N * H); end
    if (dn !== 1)         begin n_fail++; $display("FAIL basic_done_count got=%0d expected=1", dn); end
    // Done lands 100 cycles after the first issue: a 101-cycle span counted inclusively.
    if (dt !== last)      begin n_fail++; $display("FAIL basic_done_time got=%0d expected=%0d", dt, last); end
    if (hz !== 0)         begin n_fail++; $display("FAIL hazard_alignment got=%0d bad stages expected=0", hz); end
  endtask

  task automatic test_zero_latency();
    int wr, rd, dn, dt, hz;
    idle_cycles($urandom_range(1, 8));
    play_run(1'b1, 0, LOG2N * H + 3, 1'b0, 1'b0, wr, rd, dn, dt, hz);
    n_tests += 5;
    if (wr !== LOG2N * H) begin n_fail++; $display("FAIL zero_wr_count got=%0d expected=%0d", wr, LOG2N * H); end
    if (rd !== LOG2N * H) begin n_fail++; $display("FAIL zero_rd_count got=%0d expected=%0d", rd, LOG2N * H); end
    if (dn !== 1)         begin n_fail++; $display("FAIL zero_done_count got=%0d expected=1", dn); end
    if (dt !== LOG2N * H) begin n_fail++; $display("FAIL zero_done_time got=%0d expected=%0d", dt, LOG2N * H); end
    if (hz !== 0)         begin n_fail++; $display("FAIL zero_alignment got=%0d bad stages expected=0", hz); end
  endtask

  task automatic test_start_while_busy();
    int wr, rd, dn, dt, hz;
    int last = LOG2N * (H + LAT);
    idle_cycles($urandom_range(LAT + 1, 10));
    play_run(1'b0, LAT, 2 * last + 2 + LAT + 3, 1'b1, 1'b1, wr, rd, dn, dt, hz);
    n_tests += 4;
    if (dn !== 2)             begin n_fail++; $display("FAIL busy_done_count got=%0d expected=2", dn); end
    if (dt !== last)          begin n_fail++; $display("FAIL busy_done_time got=%0d expected=%0d", dt, last); end
    if (wr !== 2 * LOG2N * H) begin n_fail++; $display("FAIL busy_wr_count got=%0d expected=%0d", wr, 2 * LOG2N * H); end
    if (hz !== 0)             begin n_fail++; $display("FAIL busy_alignment got=%0d bad stages expected=0", hz); end
    idle_cycles($urandom_range(1, 6));
    play_run(1'b1, 0, LOG2N * H + 3, 1'b1, 1'b0, wr, rd, dn, dt, hz);
    n_tests += 2;
    if (dn !== 1)         begin n_fail++; $display("FAIL busy_zero_done_count got=%0d expected=1", dn); end
    if (wr !== LOG2N * H) begin n_fail++; $display("FAIL busy_zero_wr_count got=%0d expected=%0d", wr, LOG2N * H); end
  endtask

  task automatic test_reset_mid_run();
    int   wr, rd, dn, dt, hz;
    obs_t got;
    idle_cycles($urandom_range(LAT + 1, 10));
    // Stop while stage 2, pair 7 is on the read side, then reset.
    play_run(1'b0, LAT, 2 * (H + LAT) + 7, 1'b0, 1'b0, wr, rd, dn, dt, hz);
    reset_a = 1'b1;
    idle_cycles(1);
    reset_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      got = observe(1'b0);
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_run cycle=%0d got=%h expected=0", c, got);
      end
      if (c < 4) idle_cycles(1);
    end
    play_run(1'b0, LAT, LOG2N * (H + LAT) + LAT + 3, 1'b0, 1'b0, wr, rd, dn, dt, hz);
    n_tests += 2;
    if (wr !== LOG2N * H) begin n_fail++; $display("FAIL post_reset_wr_count got=%0d expected=%0d", wr, LOG2N * H); end
    if (dn !== 1)         begin n_fail++; $display("FAIL post_reset_done_count got=%0d expected=1", dn); end
    // Random reset point on the zero-latency instance.
    idle_cycles(2);
    play_run(1'b1, 0, $urandom_range(1, LOG2N * H - 1), 1'b0, 1'b0, wr, rd, dn, dt, hz);
    reset_z = 1'b1;
    idle_cycles(1);
    reset_z = 1'b0;
    got = observe(1'b1);
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_random_zero got=%h expected=0", got);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic_run();
    test_zero_latency();
    test_start_while_busy();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
